// File: rtl/led_alarm_driver.sv
// LED output stage for the self-destruct countdown: maps the saturated count onto
// four board LEDs (dark / binary / blinking / solid) and latches the terminal state.
module led_alarm_driver #(
    parameter int unsigned TERMINAL   = 10,
    parameter int unsigned CRIT_LEVEL = 7,
    parameter int unsigned BLINK_DIV  = 1,
    parameter int unsigned HOLD_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic [3:0] cnt_in,
    input  logic       clear,
    output logic [3:0] leds,
    output logic       dead,
    output logic [1:0] state_o
);

    localparam int unsigned BcW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned HcW = $clog2(HOLD_TICKS + 1);

    localparam logic [3:0]     TermCount = 4'(TERMINAL);
    localparam logic [3:0]     CritCount = 4'(CRIT_LEVEL);
    localparam logic [BcW-1:0] BlinkLast = BcW'(BLINK_DIV - 1);
    localparam logic [HcW-1:0] HoldMax   = HcW'(HOLD_TICKS);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StCrit  = 2'd2,
        StDead  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     eff_cnt;
    logic           release_ok;
    logic           blink_phase_q, blink_phase_d;
    logic [BcW-1:0] blink_cnt_q, blink_cnt_d;
    logic [HcW-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]     leds_d;

    // Saturate rather than wrap: anything past TERMINAL is terminal.
    always_comb begin
        eff_cnt = (cnt_in > TermCount) ? TermCount : cnt_in;
    end

    // Exit from DEAD uses the registered hold count, so a clear arriving on the
    // same edge the hold completes is not honoured.
    always_comb begin
        release_ok = (state_q == StDead) && (hold_cnt_q == HoldMax) && clear &&
                     (eff_cnt == 4'd0);
    end

    always_comb begin
        state_d = StIdle;
        if (state_q == StDead && !release_ok) begin
            state_d = StDead;
        end else if (state_q == StDead) begin
            state_d = StIdle;
        end else if (eff_cnt == TermCount) begin
            state_d = StDead;
        end else if (eff_cnt >= CritCount) begin
            state_d = StCrit;
        end else if (eff_cnt != 4'd0) begin
            state_d = StArmed;
        end else begin
            state_d = StIdle;
        end
    end

    always_comb begin
        blink_phase_d = blink_phase_q;
        blink_cnt_d   = blink_cnt_q;
        if (state_d == StCrit) begin
            if (state_q != StCrit) begin
                blink_phase_d = 1'b1;
                blink_cnt_d   = '0;
            end else if (tick_en) begin
                if (blink_cnt_q == BlinkLast) begin
                    blink_phase_d = ~blink_phase_q;
                    blink_cnt_d   = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d == StDead) begin
            if (state_q != StDead) begin
                hold_cnt_d = '0;
            end else if (tick_en && hold_cnt_q != HoldMax) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    // LED pattern follows the next state so it lands on the same edge as state_o.
    always_comb begin
        leds_d = 4'h0;
        unique case (state_d)
            StIdle:  leds_d = 4'h0;
            StArmed: leds_d = eff_cnt;
            StCrit:  leds_d = blink_phase_d ? 4'hF : 4'h0;
            StDead:  leds_d = 4'hF;
            default: leds_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            blink_phase_q <= 1'b1;
            blink_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            leds          <= 4'h0;
            dead          <= 1'b0;
        end else begin
            state_q       <= state_d;
            blink_phase_q <= blink_phase_d;
            blink_cnt_q   <= blink_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            leds          <= leds_d;
            dead          <= (state_d == StDead);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_led_alarm_driver.sv
// Self-checking bench for led_alarm_driver: directed cases followed by random stimulus
// compared against a tick-counting behavioural model.
module tb_led_alarm_driver;

    localparam int TERMINAL   = 10;
    localparam int CRIT_LEVEL = 7;
    localparam int BLINK_DIV  = 1;
    localparam int HOLD_TICKS = 3;

    logic       clk;
    logic       reset;
    logic       tick_en;
    logic [3:0] cnt_in;
    logic       clear;
    logic [3:0] leds;
    logic       dead;
    logic [1:0] state_o;

    int n_checks;
    int n_errors;

    // Model: state as 0..3, plus ticks elapsed since entering CRITICAL / DEAD.
    int m_state;
    int m_crit_ticks;
    int m_dead_ticks;
    int m_leds;

    led_alarm_driver #(
        .TERMINAL   (TERMINAL),
        .CRIT_LEVEL (CRIT_LEVEL),
        .BLINK_DIV  (BLINK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick_en (tick_en),
        .cnt_in  (cnt_in),
        .clear   (clear),
        .leds    (leds),
        .dead    (dead),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state      = 0;
        m_crit_ticks = 0;
        m_dead_ticks = 0;
        m_leds       = 0;
    endtask

    // Advance the model using the current inputs, clock the DUT, then compare.
    task automatic cycle();
        int c;
        int ns;
        bit phase;
        c = (int'(cnt_in) > TERMINAL) ? TERMINAL : int'(cnt_in);
        if (m_state == 3 && !(m_dead_ticks >= HOLD_TICKS && clear && c == 0)) ns = 3;
        else if (m_state == 3) ns = 0;
        else if (c == TERMINAL) ns = 3;
        else if (c >= CRIT_LEVEL) ns = 2;
        else if (c >= 1) ns = 1;
        else ns = 0;

        if (ns == 2) begin
            if (m_state != 2) m_crit_ticks = 0;
            else if (tick_en) m_crit_ticks++;
        end
        if (ns == 3) begin
            if (m_state != 3) m_dead_ticks = 0;
            else if (tick_en && m_dead_ticks < HOLD_TICKS) m_dead_ticks++;
        end
        phase = ((m_crit_ticks / BLINK_DIV) % 2) == 0;

        case (ns)
            0:       m_leds = 0;
            1:       m_leds = c;
            2:       m_leds = phase ? 15 : 0;
            default: m_leds = 15;
        endcase
        m_state = ns;

        @(posedge clk);
        #1;
        check_eq("leds", int'(leds), m_leds);
        check_eq("dead", int'(dead), (m_state == 3) ? 1 : 0);
        check_eq("state_o", int'(state_o), m_state);
    endtask

    task automatic drive(input int cnt, input bit tick, input bit clr);
        cnt_in  = 4'(cnt);
        tick_en = tick;
        clear   = clr;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        reset = 1'b1;
        drive(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_leds", int'(leds), 0);
        check_eq("rst_dead", int'(dead), 0);
        check_eq("rst_state", int'(state_o), 0);
        @(negedge clk);
        reset = 1'b0;

        // Idle and armed
        cycle();
        check_eq("idle_state", int'(state_o), 0);
        drive(3, 0, 0);
        cycle();
        check_eq("armed_leds", int'(leds), 3);
        check_eq("armed_state", int'(state_o), 1);

        // Critical blink: F on entry, then toggles on each tick
        drive(7, 0, 0);
        cycle();
        check_eq("crit_entry", int'(leds), 15);
        drive(7, 1, 0);
        cycle();
        check_eq("crit_tick1", int'(leds), 0);
        cycle();
        check_eq("crit_tick2", int'(leds), 15);
        drive(7, 0, 0);
        cycle();
        check_eq("crit_notick", int'(leds), 15);

        // Dead, early clear ignored, release after hold elapses
        drive(10, 0, 0);
        cycle();
        check_eq("dead_flag", int'(dead), 1);
        check_eq("dead_leds", int'(leds), 15);
        drive(0, 1, 1);
        cycle();
        cycle();
        check_eq("dead_hold2", int'(state_o), 3);
        cycle();
        check_eq("dead_hold3_same_edge", int'(state_o), 3);
        drive(0, 0, 1);
        cycle();
        check_eq("release_state", int'(state_o), 0);
        check_eq("release_leds", int'(leds), 0);

        // Saturation of 15 to terminal
        drive(15, 0, 0);
        cycle();
        check_eq("sat_state", int'(state_o), 3);
        check_eq("sat_leds", int'(leds), 15);
        drive(0, 1, 1);
        repeat (3) cycle();
        drive(0, 0, 1);
        cycle();
        check_eq("sat_release", int'(state_o), 0);

        // Jump 0 -> 10 in one cycle
        drive(10, 0, 0);
        cycle();
        check_eq("jump_state", int'(state_o), 3);
        check_eq("jump_dead", int'(dead), 1);

        // Async reset mid-DEAD, between edges
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_leds", int'(leds), 0);
        check_eq("async_dead", int'(dead), 0);
        check_eq("async_state", int'(state_o), 0);
        model_reset();
        drive(0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Random stimulus, biased toward zero so DEAD is exited now and then
        for (int i = 0; i < 3000; i++) begin
            int r;
            int cnt;
            r = int'($urandom_range(0, 9));
            if (r < 3) cnt = 0;
            else cnt = int'($urandom_range(0, 15));
            drive(cnt, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
